rx_packet_buffer: RTL
=====================

# rx_packet_buffer

Store-and-forward packet buffer on the adapter RX path, directly upstream of the C2H packet filter. Accepts 512-bit AXI-Stream beats from the CMAC adapter without back-pressure, holds each packet until its last beat arrives, and forwards only complete packets to the filter. A packet that cannot fit is dropped whole by rolling the speculative write pointer back, so the filter never sees a truncated frame.

## Interface
- DEPTH, 64: buffer depth in beats; power of two, 4 to 1024.
- axis_aclk  in  1  single clock for the whole block.
- axis_aresetn  in  1  reset; asynchronous, active-low.
- s_axis_tvalid  in  1  upstream beat valid.
- s_axis_tdata  in  512  upstream data.
- s_axis_keep  in  64  upstream byte enables.
- s_axis_tlast  in  1  upstream last beat of packet.
- s_axis_tuser  in  48  upstream sideband, carried with every beat.
- s_axis_tready  out  1  upstream ready.
- m_axis_tvalid / m_axis_tdata / m_axis_keep / m_axis_tlast / m_axis_tuser  out  1/512/64/1/48  to the packet filter.
- m_axis_tready  in  1  filter ready.
- fill_level  out  $clog2(DEPTH)+1  beats currently held, including uncommitted beats.
- stat_rx_pkts  out  32  packets committed.
- stat_drop_pkts  out  32  packets dropped.

## Operation
- Storage: DEPTH entries of {tdata, keep, tuser, tlast}. Pointers wr_ptr (speculative), wr_commit, rd_ptr, each $clog2(DEPTH)+1 bits; MSB is the wrap bit. Occupancy = wr_ptr - rd_ptr, modulo 2^(width).
- s_axis_tready = 1 whenever out of reset; input is never stalled.
- Write FSM, states ACCEPT and DROP:
  - ACCEPT, beat accepted, occupancy < DEPTH: write at wr_ptr, wr_ptr+1. If tlast: wr_commit <= wr_ptr+1, stat_rx_pkts+1.
  - ACCEPT, beat accepted, occupancy == DEPTH: wr_ptr <= wr_commit (discard partial packet). If tlast: stat_drop_pkts+1, stay ACCEPT; else go DROP.
  - DROP: discard every beat; on tlast, stat_drop_pkts+1, return to ACCEPT.
- Full check uses rd_ptr at the start of the cycle; a read in the same cycle does not rescue the beat.
- Packets longer than DEPTH beats are always dropped.
- Read side: data available while rd_ptr != wr_commit; one output register stage (skid-free prefetch) drives m_axis_*. rd_ptr advances when the output register is loaded.
- Counters wrap modulo 2^32.

## Timing
- Reset (asynchronous assert, synchronous deassert handled upstream): all pointers 0, FSM ACCEPT, s_axis_tready 0, m_axis_tvalid 0, m_axis_tdata/keep/tlast/tuser 0, fill_level 0, counters 0. In-flight and stored packets are lost; no partial output after reset.
- Latency: tlast accepted in cycle N; first beat of that packet presents m_axis_tvalid in cycle N+2 when the buffer was empty.
- Throughput: one beat per cycle sustained when m_axis_tready is held high.
- AXI-Stream rules on m_axis: once tvalid is high, tvalid and all payload hold stable until tready; transfer on tvalid && tready.
- Simultaneous write and read: both take effect; fill_level reflects both next cycle.
- Commit and output loading in the same cycle on an empty buffer: the output is loaded the following cycle (N+2 rule).

## Configuration
- RX_PACKET_BUFFER_STATS_EN: defined, stat_rx_pkts and stat_drop_pkts count as above. Not defined, counter logic is omitted and both outputs are tied to 0. Buffering and drop behaviour are identical in both builds.

## Test plan
- Single 4-beat packet, tready=1, DEPTH=64 -> first m_axis beat 2 cycles after input tlast, 4 beats identical in data/keep/tuser, tlast on beat 4, stat_rx_pkts=1.
- m_axis_tready=0; send 16 packets of 4 beats -> fill_level=64. Send a 17th 3-beat packet -> dropped, wr_ptr restored, stat_drop_pkts=1. Release tready -> exactly 64 beats (16 packets) out.
- 100-beat packet with DEPTH=64 and an empty buffer -> no output, stat_drop_pkts=1, fill_level returns to 0. A following 2-beat packet passes intact.
- Occupancy 62, tready=0, 5-beat packet arrives -> beats 1-2 written, beat 3 triggers rollback to 62, beats 4-5 discarded, stat_drop_pkts+1, prior packets unaffected.
- Random tready at 50%, 1000 packets of 1-20 beats, input rate under drain rate -> output stream equals input stream beat for beat, stat_rx_pkts=1000, stat_drop_pkts=0.
- Assert axis_aresetn low mid-packet, both on input and on output -> all outputs zero immediately. After release, a new 2-beat packet passes alone with no residue from before reset.

Source files
------------

// File: rtl/rx_packet_buffer.sv
// rx_packet_buffer: store-and-forward RX packet buffer; forwards only complete packets, drops overflowing ones whole.
// Optional packet counters enabled by defining RX_PACKET_BUFFER_STATS_EN.
`default_nettype none

module rx_packet_buffer #(
  parameter int DEPTH = 64
) (
  input  logic                       axis_aclk,
  input  logic                       axis_aresetn,
  input  logic                       s_axis_tvalid,
  input  logic [511:0]               s_axis_tdata,
  input  logic [63:0]                s_axis_keep,
  input  logic                       s_axis_tlast,
  input  logic [47:0]                s_axis_tuser,
  output logic                       s_axis_tready,
  output logic                       m_axis_tvalid,
  output logic [511:0]               m_axis_tdata,
  output logic [63:0]                m_axis_keep,
  output logic                       m_axis_tlast,
  output logic [47:0]                m_axis_tuser,
  input  logic                       m_axis_tready,
  output logic [$clog2(DEPTH):0]     fill_level,
  output logic [31:0]                stat_rx_pkts,
  output logic [31:0]                stat_drop_pkts
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int BW = 512 + 64 + 48 + 1;

  typedef enum logic [0:0] {ACCEPT = 1'b0, DROP = 1'b1} wr_state_t;

  wr_state_t       state, state_next;
  logic [PW-1:0]   wr_ptr, wr_ptr_next, wr_commit, wr_commit_next, rd_ptr;
  logic [PW-1:0]   occupancy;
  logic            full, beat_in, wr_en, rx_inc, drop_inc;
  logic            avail, load;
  logic [BW-1:0]   mem [DEPTH];
  logic [BW-1:0]   rd_word;

  assign occupancy = wr_ptr - rd_ptr;
  assign full      = (occupancy == PW'(DEPTH));
  assign beat_in   = s_axis_tvalid && s_axis_tready;

  always_comb begin
    state_next     = state;
    wr_en          = 1'b0;
    wr_ptr_next    = wr_ptr;
    wr_commit_next = wr_commit;
    rx_inc         = 1'b0;
    drop_inc       = 1'b0;
    case (state)
      ACCEPT: begin
        if (beat_in) begin
          if (!full) begin
            wr_en       = 1'b1;
            wr_ptr_next = wr_ptr + PW'(1);
            if (s_axis_tlast) begin
              wr_commit_next = wr_ptr + PW'(1);
              rx_inc         = 1'b1;
            end
          end else begin
            // No room: discard whatever of this packet was already written.
            wr_ptr_next = wr_commit;
            if (s_axis_tlast) drop_inc = 1'b1;
            else              state_next = DROP;
          end
        end
      end
      DROP: begin
        if (beat_in && s_axis_tlast) begin
          drop_inc   = 1'b1;
          state_next = ACCEPT;
        end
      end
      default: state_next = ACCEPT;
    endcase
  end

  always_ff @(posedge axis_aclk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= {s_axis_tdata, s_axis_keep, s_axis_tuser, s_axis_tlast};
  end

  assign avail   = (rd_ptr != wr_commit);
  assign load    = avail && (!m_axis_tvalid || m_axis_tready);
  assign rd_word = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      state         <= ACCEPT;
      wr_ptr        <= '0;
      wr_commit     <= '0;
      rd_ptr        <= '0;
      s_axis_tready <= 1'b0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_keep   <= '0;
      m_axis_tuser  <= '0;
      m_axis_tlast  <= 1'b0;
    end else begin
      state         <= state_next;
      wr_ptr        <= wr_ptr_next;
      wr_commit     <= wr_commit_next;
      s_axis_tready <= 1'b1;
      if (load) begin
        {m_axis_tdata, m_axis_keep, m_axis_tuser, m_axis_tlast} <= rd_word;
        m_axis_tvalid <= 1'b1;
        rd_ptr        <= rd_ptr + PW'(1);
      end else if (m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end
    end
  end

  // The beat parked in the output register is still held, so it counts toward the fill level.
  assign fill_level = occupancy + PW'(m_axis_tvalid);

`ifdef RX_PACKET_BUFFER_STATS_EN
  logic [31:0] rx_cnt, drop_cnt;

  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      rx_cnt   <= '0;
      drop_cnt <= '0;
    end else begin
      if (rx_inc)   rx_cnt   <= rx_cnt + 32'd1;
      if (drop_inc) drop_cnt <= drop_cnt + 32'd1;
    end
  end

  assign stat_rx_pkts   = rx_cnt;
  assign stat_drop_pkts = drop_cnt;
`else
  logic unused_stats;
  assign unused_stats   = rx_inc ^ drop_inc;
  assign stat_rx_pkts   = 32'd0;
  assign stat_drop_pkts = 32'd0;
`endif

endmodule

`default_nettype wire
